// File: rtl/dp_pkg.sv
// Shared definitions for the sequential datapath: op-code values and FSM states.
package dp_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add unsigned multiplier: loads on start, iterates exactly WIDTH cycles.
// done is asserted during the final iteration cycle, with product presenting
// the completed value so the caller can capture it on that same edge.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic            busy;
    logic [PW-1:0]   mcand;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]   cnt;

    // One partial-product step: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    assign done    = busy && (cnt == CW'(1));
    assign product = acc_next;

    // Iteration state: load operands on start, then shift/accumulate once per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end else if (start) begin
            mcand  <= PW'(a);
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
            busy   <= 1'b1;
        end
    end

endmodule

// File: rtl/seq_datapath.sv
// Sequential datapath: register file, single-cycle ALU and a multi-cycle
// multiplier, sequenced by an IDLE/EXEC/MUL controller.
module seq_datapath
    import dp_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int ADDR    = 3,
    parameter int R0_ZERO = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [ADDR-1:0]  rs1,
    input  logic [ADDR-1:0]  rs2,
    input  logic [ADDR-1:0]  rd,
    input  logic             use_imm,
    input  logic [WIDTH-1:0] imm,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    input  logic [ADDR-1:0]  dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    localparam int          PW   = 2 * WIDTH;
    localparam int          SHW  = $clog2(WIDTH);
    localparam int unsigned NREG = 1 << ADDR;

    state_e           state;
    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] rs1_val, rs2_val, opb_val;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       op_q;
    logic [ADDR-1:0]  rd_q;
    logic [WIDTH-1:0] alu_res, fin_res;
    logic             alu_carry, fin_carry;
    logic             wr_en, mul_start, mul_done;
    logic [PW-1:0]    mul_product;

    assign rs1_val  = (R0_ZERO != 0 && rs1 == '0) ? '0 : regs[rs1];
    assign rs2_val  = (R0_ZERO != 0 && rs2 == '0) ? '0 : regs[rs2];
    assign dbg_data = (R0_ZERO != 0 && dbg_addr == '0) ? '0 : regs[dbg_addr];
    assign opb_val  = use_imm ? imm : rs2_val;

    // The multiplier loads straight from the operand mux on the accepting edge,
    // so its WIDTH iterations line up with the WIDTH cycles spent in MUL.
    assign mul_start = start && (state == S_IDLE) && (op == OP_MUL);

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (rs1_val),
        .b       (opb_val),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle ALU on the latched operands.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB: begin
                alu_res   = a_q - b_q;
                alu_carry = (a_q < b_q);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_SLT: alu_res[0] = ($signed(a_q) < $signed(b_q));
            OP_SHL: alu_res = a_q << b_q[SHW-1:0];
            OP_SHR: alu_res = a_q >> b_q[SHW-1:0];
            default: ;
        endcase
    end

    // Select the completing result/flag and decide whether this edge completes an op.
    always_comb begin
        fin_res   = alu_res;
        fin_carry = alu_carry;
        wr_en     = (state == S_EXEC);
        if (state == S_MUL) begin
            fin_res   = mul_product[WIDTH-1:0];
            fin_carry = |mul_product[PW-1:WIDTH];
            wr_en     = mul_done;
        end
    end

    // Register file: reset clears all entries; writes to entry 0 are dropped when it is hardwired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && !(R0_ZERO != 0 && rd_q == '0)) begin
            regs[rd_q] <= fin_res;
        end
    end

    // Controller: accept in IDLE, latch operands, complete from EXEC or MUL with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= OP_AND;
            rd_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= rs1_val;
                        b_q   <= opb_val;
                        op_q  <= op;
                        rd_q  <= rd;
                        busy  <= 1'b1;
                        state <= (op == OP_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC, S_MUL: begin
                    if (wr_en) begin
                        result <= fin_res;
                        zero   <= (fin_res == '0);
                        carry  <= fin_carry;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_datapath.sv
// Self-checking bench for seq_datapath: behavioural reference model checked
// every cycle, directed literal scenarios, then randomized traffic.
module tb_seq_datapath;

    localparam int W = 16;
    localparam int A = 3;

    localparam logic [2:0] C_AND = 3'b000;
    localparam logic [2:0] C_OR  = 3'b001;
    localparam logic [2:0] C_ADD = 3'b010;
    localparam logic [2:0] C_MUL = 3'b011;
    localparam logic [2:0] C_SUB = 3'b110;
    localparam logic [2:0] C_SLT = 3'b111;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [A-1:0] rs1 = '0, rs2 = '0, rd = '0, dbg_addr = '0;
    logic         use_imm = 1'b0;
    logic [W-1:0] imm = '0;
    logic         busy, done, zero, carry;
    logic [W-1:0] result, dbg_data;

    always #5 clk = ~clk;

    seq_datapath #(.WIDTH(W), .ADDR(A), .R0_ZERO(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .use_imm  (use_imm),
        .imm      (imm),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] m_regs [1 << A];
    bit           m_pend;
    int           m_left;
    logic [W-1:0] m_pres;
    bit           m_pc;
    logic [A-1:0] m_prd;
    logic         m_busy, m_done, m_zero, m_carry;
    logic [W-1:0] m_result;
    logic [W-1:0] ma, mb;

    task automatic model_reset();
        for (int i = 0; i < (1 << A); i++) m_regs[i] = '0;
        m_pend = 0; m_left = 0; m_busy = 1'b0; m_done = 1'b0;
        m_result = '0; m_zero = 1'b0; m_carry = 1'b0;
    endtask

    function automatic void model_eval(input logic [2:0] o, input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       output logic [W-1:0] r, output bit c);
        longint unsigned full;
        c = 0;
        r = '0;
        case (o)
            3'b010: begin full = longint'(a) + longint'(b); r = full[W-1:0]; c = full[W]; end
            3'b110: begin r = a - b; c = (a < b); end
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b111: r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            3'b011: begin full = longint'(a) * longint'(b); r = full[W-1:0]; c = ((full >> W) != 0); end
            3'b100: r = a << b[$clog2(W)-1:0];
            3'b101: r = a >> b[$clog2(W)-1:0];
            default: ;
        endcase
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                m_done = 1'b0;
                if (m_pend) begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_prd != 0) m_regs[m_prd] = m_pres;
                        m_result = m_pres;
                        m_zero   = (m_pres == 0);
                        m_carry  = m_pc;
                        m_done   = 1'b1;
                        m_pend   = 0;
                    end
                end else if (start === 1'b1) begin
                    ma = m_regs[rs1];
                    mb = use_imm ? imm : m_regs[rs2];
                    model_eval(op, ma, mb, m_pres, m_pc);
                    m_prd  = rd;
                    m_left = (op == C_MUL) ? W : 1;
                    m_pend = 1;
                end
                m_busy = m_pend;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("busy",     64'(busy),     64'(m_busy));
            chk("done",     64'(done),     64'(m_done));
            chk("result",   64'(result),   64'(m_result));
            chk("zero",     64'(zero),     64'(m_zero));
            chk("carry",    64'(carry),    64'(m_carry));
            chk("dbg_data", 64'(dbg_data), 64'(m_regs[dbg_addr]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input logic [2:0] o, input logic [A-1:0] s1, input logic [A-1:0] s2,
                          input logic [A-1:0] d, input logic ui, input logic [W-1:0] im,
                          output int edges);
        op = o; rs1 = s1; rs2 = s2; rd = d; use_imm = ui; imm = im; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        while (done !== 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        if (done !== 1'b1) chk("done_timeout", 64'(0), 64'(1));
    endtask

    int e;
    int ndone;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   64'(busy),   64'(0));
        chk("rst_done",   64'(done),   64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_zero",   64'(zero),   64'(0));
        chk("rst_carry",  64'(carry),  64'(0));
        rst_n = 1'b1;

        // first edge after release accepts; then add wrapping to zero
        run_op(C_OR, 0, 0, 1, 1, 16'h0005, e);
        chk("first_accept_edges", 64'(e), 64'(2));
        chk("or_imm_result", 64'(result), 64'h0005);
        run_op(C_ADD, 1, 0, 3, 1, 16'hFFFB, e);
        chk("back_to_back_edges", 64'(e), 64'(2));
        chk("add_result", 64'(result), 64'h0000);
        chk("add_zero",   64'(zero),   64'(1));
        chk("add_carry",  64'(carry),  64'(1));

        // slt / sub
        run_op(C_OR, 0, 0, 1, 1, 16'h0003, e);
        run_op(C_OR, 0, 0, 2, 1, 16'h8000, e);
        run_op(C_SLT, 2, 1, 4, 0, '0, e);
        chk("slt_result", 64'(result), 64'h0001);
        run_op(C_SUB, 1, 2, 5, 0, '0, e);
        chk("sub_result", 64'(result), 64'h8003);
        chk("sub_borrow", 64'(carry),  64'(1));
        dbg_addr = 3'd5;
        @(negedge clk);
        chk("dbg_reg5", 64'(dbg_data), 64'h8003);

        // rd aliasing a source
        run_op(C_ADD, 1, 1, 1, 0, '0, e);
        chk("alias_result", 64'(result), 64'h0006);
        run_op(C_ADD, 1, 0, 6, 1, '0, e);
        chk("alias_reread", 64'(result), 64'h0006);

        // mul latency and busy
        run_op(C_OR, 0, 0, 1, 1, 16'h0100, e);
        run_op(C_OR, 0, 0, 2, 1, 16'h0101, e);
        op = C_MUL; rs1 = 3'd1; rs2 = 3'd2; rd = 3'd6; use_imm = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = 1;
        while (done !== 1'b1 && e < 100) begin
            chk("mul_busy", 64'(busy), 64'(1));
            @(negedge clk);
            e++;
        end
        chk("mul_edges",  64'(e),      64'(W + 1));
        chk("mul_result", 64'(result), 64'h0100);
        chk("mul_carry",  64'(carry),  64'(1));

        // start held high during a mul: one completion only
        op = C_MUL; rs1 = 3'd1; rs2 = 3'd2; rd = 3'd7; use_imm = 1'b0; start = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        start = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("held_start_ops", 64'(ndone), 64'(1));

        // write to r0 dropped
        run_op(C_OR, 0, 0, 0, 1, 16'h1234, e);
        chk("r0_result", 64'(result), 64'h1234);
        dbg_addr = 3'd0;
        @(negedge clk);
        chk("r0_dbg", 64'(dbg_data), 64'h0000);

        // reset mid-mul
        op = C_MUL; rs1 = 3'd1; rs2 = 3'd0; rd = 3'd3; use_imm = 1'b1; imm = 16'h0007; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dbg_addr = 3'd3;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort_no_done", 64'(ndone),    64'(0));
        chk("abort_rd_zero", 64'(dbg_data), 64'h0000);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start    = 1'($urandom_range(0, 1));
            op       = 3'($urandom_range(0, 7));
            rs1      = 3'($urandom_range(0, 7));
            rs2      = 3'($urandom_range(0, 7));
            rd       = 3'($urandom_range(0, 7));
            dbg_addr = 3'($urandom_range(0, 7));
            use_imm  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: imm = 16'h0000;
                1: imm = 16'hFFFF;
                2: imm = 16'h8000;
                3: imm = 16'($urandom_range(0, 15));
                default: imm = 16'($urandom);
            endcase
            rst_n = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
